// File: rtl/counter_pkg.sv
// Shared constants and state type for the n-bit one-shot / repeating tick counter.
package counter_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge pulse generator; STAGES > 0 synchronises an asynchronous input first
// and registers the pulse, STAGES = 0 treats the input as a same-domain level.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  import counter_pkg::*;

  if (STAGES == 0) begin : g_direct
    logic din_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) din_d <= 1'b0;
      else        din_d <= din;
    end

    // Combinational so the consumer acts on the edge right after the rise is seen.
    assign pulse = din & ~din_d;
  end else begin : g_sync
    logic [STAGES-1:0] sync_q;
    logic              lvl_d;
    logic              pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        lvl_d   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q[0] <= din;
        for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        lvl_d   <= sync_q[STAGES-1];
        pulse_q <= sync_q[STAGES-1] & ~lvl_d;
      end
    end

    assign pulse = pulse_q;
  end

endmodule

// File: rtl/counter_nbit_oneshot.sv
// Tick counter between 0 and a latched limit, up or down, one run per start request
// or continuously; abortable, with a registered terminal carry pulse and busy flag.
module counter_nbit_oneshot
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             qzt_clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             run,
  input  logic             abort,
  input  logic             mode_repeat,
  input  logic             dir_down,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] out_nx, lim_q, lim_nx;
  logic [WIDTH-1:0] start_val, term_val, step_val;
  logic             rep_q, rep_nx, dn_q, dn_nx;
  logic             carry_nx, start_p, tick;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_run_edge (
    .clk   (qzt_clk),
    .rst_n (rst_n),
    .din   (run),
    .pulse (start_p)
  );

  sync_edge_detect #(.STAGES(0)) u_tick_edge (
    .clk   (qzt_clk),
    .rst_n (rst_n),
    .din   (clk_in),
    .pulse (tick)
  );

  assign start_val = dn_q ? lim_q : '0;
  assign term_val  = dn_q ? '0 : lim_q;
  assign step_val  = dn_q ? out - WIDTH'(1) : out + WIDTH'(1);

  always_comb begin
    state_nx = state;
    out_nx   = out;
    carry_nx = 1'b0;
    lim_nx   = lim_q;
    rep_nx   = rep_q;
    dn_nx    = dn_q;
    case (state)
      ST_IDLE: begin
        if (start_p && !abort) begin
          lim_nx   = limit;
          rep_nx   = mode_repeat;
          dn_nx    = dir_down;
          out_nx   = dir_down ? limit : '0;
          carry_nx = (limit == '0);
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (out == term_val) begin
          // Only a zero limit gets here in one-run mode: leave after the one busy cycle.
          if (!rep_q)    state_nx = ST_IDLE;
          else if (tick) out_nx   = start_val;
        end else if (tick) begin
          out_nx = step_val;
          if (step_val == term_val) begin
            carry_nx = 1'b1;
            if (!rep_q) state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out   <= '0;
      carry <= 1'b0;
      lim_q <= '0;
      rep_q <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      state <= state_nx;
      out   <= out_nx;
      carry <= carry_nx;
      lim_q <= lim_nx;
      rep_q <= rep_nx;
      dn_q  <= dn_nx;
    end
  end

  assign busy = (state == ST_COUNT);

endmodule

// File: tb/tb_counter_nbit_oneshot.sv
// Directed + randomized bench for counter_nbit_oneshot; two widths run in lockstep
// against a tick-position reference model.
module tb_counter_nbit_oneshot;

  localparam int SYNC = 2;

  logic        qzt_clk = 1'b0;
  logic        rst_n;
  logic        clk_in;
  logic        run, abort, mode_repeat, dir_down;
  logic [11:0] limit;
  logic [7:0]  out8;
  logic [11:0] out12;
  logic        carry8, carry12, busy8, busy12;

  counter_nbit_oneshot #(.WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .clk_in(clk_in), .run(run), .abort(abort),
    .mode_repeat(mode_repeat), .dir_down(dir_down), .limit(limit[7:0]),
    .out(out8), .carry(carry8), .busy(busy8)
  );

  counter_nbit_oneshot #(.WIDTH(12), .SYNC_STAGES(SYNC)) u_dut12 (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .clk_in(clk_in), .run(run), .abort(abort),
    .mode_repeat(mode_repeat), .dir_down(dir_down), .limit(limit),
    .out(out12), .carry(carry12), .busy(busy12)
  );

  always #5 qzt_clk = ~qzt_clk;

  // Divided clock: level changes 1 time unit after every second rising edge.
  initial begin
    clk_in = 1'b0;
    forever begin
      repeat (2) @(posedge qzt_clk);
      #1 clk_in = ~clk_in;
    end
  end

  // Reference model: position p = ticks since start within 0..limit; out maps p by direction.
  int unsigned m_lim[2], m_p[2], m_out[2];
  bit          m_busy[2], m_carry[2], m_rep[2], m_dn[2];
  bit          clk_prev, run_prev;
  int          start_cd;
  int          car_cnt[2];
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lim[k] = 0; m_p[k] = 0; m_out[k] = 0;
      m_busy[k] = 0; m_carry[k] = 0; m_rep[k] = 0; m_dn[k] = 0;
    end
    clk_prev = 0; run_prev = 0; start_cd = -1;
  endtask

  task automatic model_step();
    bit          tick, start;
    int unsigned lim;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick     = clk_in && !clk_prev;
    clk_prev = clk_in;
    start    = (start_cd == 0);
    if (start_cd >= 0) start_cd--;
    if (run && !run_prev) start_cd = SYNC;
    run_prev = run;
    for (int k = 0; k < 2; k++) begin
      lim = 32'(limit) & ((k == 0) ? 32'hFF : 32'hFFF);
      m_carry[k] = 0;
      if (!m_busy[k]) begin
        if (start && !abort) begin
          m_lim[k] = lim; m_rep[k] = mode_repeat; m_dn[k] = dir_down;
          m_p[k] = 0; m_busy[k] = 1; m_carry[k] = (lim == 0);
        end
      end else if (abort) begin
        m_busy[k] = 0;
      end else if (m_p[k] == m_lim[k]) begin
        if (!m_rep[k]) m_busy[k] = 0;
        else if (tick) m_p[k] = 0;
      end else if (tick) begin
        m_p[k]++;
        if (m_p[k] == m_lim[k]) begin
          m_carry[k] = 1;
          if (!m_rep[k]) m_busy[k] = 0;
        end
      end
      m_out[k] = m_dn[k] ? m_lim[k] - m_p[k] : m_p[k];
    end
  endtask

  task automatic check_all();
    chk("out8",    32'(out8),    m_out[0]);
    chk("carry8",  32'(carry8),  32'(m_carry[0]));
    chk("busy8",   32'(busy8),   32'(m_busy[0]));
    chk("out12",   32'(out12),   m_out[1]);
    chk("carry12", 32'(carry12), 32'(m_carry[1]));
    chk("busy12",  32'(busy12),  32'(m_busy[1]));
    car_cnt[0] += int'(carry8);
    car_cnt[1] += int'(carry12);
  endtask

  // Each cycle: model steps on the rising edge, DUT is compared on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge qzt_clk);
      model_step();
      @(negedge qzt_clk);
      check_all();
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    cyc(4);
    run = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int bound, input string tag);
    int n = 0;
    while (m_busy[k] && n < bound) begin cyc(1); n++; end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  task automatic wait_out(input int k, input int unsigned v, input int bound, input string tag);
    int n = 0;
    while (m_out[k] != v && n < bound) begin cyc(1); n++; end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    int base, n;
    n_cmp = 0; n_err = 0;
    car_cnt[0] = 0; car_cnt[1] = 0;
    rst_n = 1'b0; run = 1'b0; abort = 1'b0;
    mode_repeat = 1'b0; dir_down = 1'b0; limit = '0;
    model_reset();
    #2;
    chk("rst_out8", 32'(out8), 0);
    chk("rst_carry8", 32'(carry8), 0);
    chk("rst_busy8", 32'(busy8), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // Up one-run, limit 5: busy appears in cycle SYNC+2 after the run rise.
    limit = 12'd5; dir_down = 1'b0; mode_repeat = 1'b0;
    base = car_cnt[0];
    run = 1'b1;
    cyc(3);
    chk("up_busy_c3", 32'(busy8), 0);
    cyc(1);
    chk("up_busy_c4", 32'(busy8), 1);
    chk("up_load", 32'(out8), 0);
    run = 1'b0;
    wait_idle(0, 100, "up_done_bound");
    chk("up_final", 32'(out8), 5);
    chk("up_carries", 32'(car_cnt[0] - base), 1);
    cyc(20);
    chk("up_hold", 32'(out8), 5);
    chk("up_idle", 32'(busy8), 0);

    // Down repeat, limit 3: 16 ticks give four entries into zero.
    limit = 12'd3; dir_down = 1'b1; mode_repeat = 1'b1;
    pulse_run();
    chk("dn_load", 32'(out8), 3);
    base = car_cnt[0];
    cyc(64);
    chk("dn_busy", 32'(busy8), 1);
    chk("dn_carries", 32'(car_cnt[0] - base), 4);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("dn_abort", 32'(busy8), 0);
    cyc(6);

    // Zero limit, one-run: carry and busy for a single cycle.
    limit = 12'd0; dir_down = 1'b0; mode_repeat = 1'b0;
    base = car_cnt[0];
    run = 1'b1;
    cyc(3);
    run = 1'b0;
    cyc(1);
    chk("z_carry", 32'(carry8), 1);
    chk("z_busy", 32'(busy8), 1);
    chk("z_out", 32'(out8), 0);
    cyc(1);
    chk("z_carry_off", 32'(carry8), 0);
    chk("z_busy_off", 32'(busy8), 0);
    cyc(10);
    chk("z_carries", 32'(car_cnt[0] - base), 1);

    // Abort coincident with a tick at out = 4.
    limit = 12'd10;
    pulse_run();
    wait_out(0, 4, 100, "ab_reach4");
    n = 0;
    while (!(clk_in && !clk_prev) && n < 8) begin cyc(1); n++; end
    chk("ab_tick_found", 32'(n < 8), 1);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("ab_out", 32'(out8), 4);
    chk("ab_busy", 32'(busy8), 0);
    chk("ab_carry", 32'(carry8), 0);
    pulse_run();
    chk("ab_rerun_out", 32'(out8), 0);
    chk("ab_rerun_busy", 32'(busy8), 1);
    wait_idle(0, 100, "ab_rerun_bound");
    chk("ab_rerun_final", 32'(out8), 10);

    // Asynchronous reset mid-cycle at out = 7.
    pulse_run();
    wait_out(0, 7, 100, "rs_reach7");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rs_out8", 32'(out8), 0);
    chk("rs_out12", 32'(out12), 0);
    chk("rs_carry", 32'(carry8), 0);
    chk("rs_busy", 32'(busy8), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    chk("rs_still_out", 32'(out8), 0);
    chk("rs_still_busy", 32'(busy8), 0);

    // Randomized runs; limit/dir changes mid-run must be ignored.
    for (int r = 0; r < 8; r++) begin
      limit       = 12'($urandom_range(0, 12));
      dir_down    = 1'($urandom_range(0, 1));
      mode_repeat = 1'($urandom_range(0, 1));
      pulse_run();
      n = $urandom_range(5, 120);
      for (int j = 0; j < n; j++) begin
        cyc(1);
        if ($urandom_range(0, 15) == 0) begin
          limit    = 12'($urandom_range(0, 15));
          dir_down = ~dir_down;
        end
      end
      if (mode_repeat || $urandom_range(0, 1) == 1) begin
        abort = 1'b1; cyc(1); abort = 1'b0;
      end
      wait_idle(0, 400, "rnd_idle8");
      wait_idle(1, 400, "rnd_idle12");
      cyc(6);
    end

    // Run held 100 cycles plus a second pulse while busy: one run only; full 12-bit range.
    limit = 12'd4095; dir_down = 1'b0; mode_repeat = 1'b0;
    base = car_cnt[1];
    n = car_cnt[0];
    run = 1'b1; cyc(100); run = 1'b0;
    cyc(6);
    run = 1'b1; cyc(5); run = 1'b0;
    wait_idle(1, 20000, "full_bound");
    chk("full_out12", 32'(out12), 4095);
    chk("full_carry12", 32'(car_cnt[1] - base), 1);
    chk("full_busy12", 32'(busy12), 0);
    chk("full_out8", 32'(out8), 255);
    chk("full_carry8", 32'(car_cnt[0] - n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_nbit_oneshot.md
Name: counter_nbit_oneshot

Overview:
- Parametrised successor to the 8-bit one-run counter.
- Counts ticks derived from a divided clock (clk_in, produced by the frequency divider in the qzt_clk domain). The count runs between 0 and a programmable limit, up or down, once per run request or continuously.
- Adds asynchronous-reset, run-input synchronisation, direction and repeat modes, abort and a busy flag.
- Sits between the button/frequency-divider logic and display or timing consumers.

Parameters:
- WIDTH, 8, width of limit and out.
- SYNC_STAGES, 2, flip-flop stages synchronising the asynchronous run input (minimum 2).

Ports:
- qzt_clk  in  1  system (quartz) clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_in  in  1  divided clock, qzt_clk-synchronous level; each rising edge is one tick.
- run  in  1  asynchronous start request (button); its rising edge starts a run.
- abort  in  1  synchronous stop, level-sensitive.
- mode_repeat  in  1  0 = one-run, 1 = continuous; latched at start.
- dir_down  in  1  0 = count up, 1 = count down; latched at start.
- limit  in  WIDTH  terminal (up) or start (down) value; latched at start.
- out  out  WIDTH  current count, registered.
- carry  out  1  one-qzt_clk pulse, registered, when out reaches the terminal value.
- busy  out  1  high while in COUNT.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; out = 0; carry = 0; busy = 0.
  - Sync chains and tick edge register = 0; latched mode/dir/limit = 0.
  - Reset overrides everything, including mid-run.
- Run path: run passes through SYNC_STAGES flops, then a rising-edge detector, giving start_p.
  - The first qzt_clk edge after run rises is cycle 1.
  - start_p is high in cycle SYNC_STAGES+1; busy and out are updated in cycle SYNC_STAGES+2.
- Tick path: tick = clk_in & ~clk_in_d, where clk_in_d is registered clk_in (no synchroniser, same domain). The count changes on the edge after tick is seen.
- Definitions: S = 0 (up) or limit (down); T = limit (up) or 0 (down), using latched values.
- State IDLE:
  - out holds its last value; carry = 0.
  - start_p latches mode/dir/limit, loads out = S and goes to COUNT.
  - If S == T (limit == 0): carry pulses with the load. One-run mode returns to IDLE immediately (busy high for 1 cycle); repeat mode stays in COUNT.
- State COUNT, on a tick:
  - If out != T: out = out ± 1. If the new value == T, carry = 1 that cycle.
  - One-run, out reaches T: transition to IDLE together with the carry pulse; out holds T.
  - Repeat, tick while out == T: out = S, no carry. Period = limit+1 ticks.
- Carry is exactly 1 cycle wide, never asserted outside a terminal-reach event.
- Arithmetic is WIDTH-bit unsigned; no wrap is possible beyond S..T.
- Precedence, highest first: rst_n, abort, tick, start_p.
- start_p while busy is ignored; no restart.
- abort in COUNT: go to IDLE next edge, out holds, carry = 0, even if a tick coincides. abort in IDLE has no effect; start_p concurrent with abort is discarded.
- limit/mode/dir changes during COUNT have no effect until the next start.
- run held high starts only once; a new start needs run low for at least SYNC_STAGES cycles.

Decomposition:
- Package counter_pkg:
  - State localparams ST_IDLE = 1'b0, ST_COUNT = 1'b1.
  - Default WIDTH and SYNC_STAGES constants.
- Sub-module sync_edge_detect (param STAGES, 0 = no sync): registered rising-edge pulse generator.
  - Instantiated for run (STAGES = SYNC_STAGES) and for clk_in (STAGES = 0).

Test Plan:
- Common setup: WIDTH = 8; clk_in toggles every 2 qzt_clk cycles (tick every 4 cycles).
- Up one-run: limit = 5, dir_down = 0, pulse run → busy in cycle 4; out 0,1,2,3,4,5 on successive ticks; single carry with out = 5; busy drops; out holds 5; later ticks leave out unchanged.
- Down repeat: limit = 3, dir_down = 1, mode_repeat = 1 → out 3,2,1,0,3,2,…; carry once per entry into 0 (every 4 ticks); busy stays high.
- limit = 0, one-run → carry and busy each high exactly one cycle; out = 0.
- Abort mid-run: limit = 10, abort at out = 4 coincident with a tick → out stays 4, no carry, IDLE; re-run restarts from 0.
- rst_n low at out = 7 (asynchronous, mid-cycle) → out, carry, busy are 0 immediately; after release no counting until a new run edge.
- run held high for 100 cycles, plus a second run pulse while busy → exactly one run; WIDTH = 12, limit = 4095 up reaches 4095 with one carry.
